// File: rtl/sram_like_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_like_arbiter
// Description : Two-master, one-slave arbiter on the sram-like protocol.
//               Merges the instruction-side and data-side channels onto the
//               single sram-like port of the AXI bridge, one outstanding
//               transaction at a time. Data has fixed priority; a
//               starvation counter forces an instruction grant after
//               STARVE_LIMIT consecutive data grants that overtook a
//               waiting instruction request.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_like_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic        clk,
    input  logic        rst,
    // instruction master
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    // data master
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    // bridge (slave) side
    output logic        req,
    output logic        wr,
    output logic [1:0]  size,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    input  logic        addr_ok,
    input  logic        data_ok,
    input  logic [31:0] rdata
);

    localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_I_ADDR = 3'd1,
        S_D_ADDR = 3'd2,
        S_I_DATA = 3'd3,
        S_D_DATA = 3'd4
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_starve_cnt;

    logic w_idle;
    logic w_starved;
    logic w_win_i;
    logic w_win_d;
    logic w_own_i;
    logic w_own_d;
    logic w_req;
    logic w_accept;

    // Grant in IDLE is decided combinationally so arbitration costs no cycle;
    // inst only beats a concurrent data request once it has been starved.
    assign w_idle    = (r_state == S_IDLE);
    assign w_starved = (r_starve_cnt == C_LIMIT);
    assign w_win_i   = w_idle & inst_req & (~data_req | w_starved);
    assign w_win_d   = w_idle & data_req & ~w_win_i;

    // Owner is the IDLE winner or the side locked while awaiting addr_ok;
    // locking keeps bridge outputs stable until the address is accepted.
    assign w_own_i   = w_win_i | (r_state == S_I_ADDR);
    assign w_own_d   = w_win_d | (r_state == S_D_ADDR);
    assign w_req     = (w_own_i & inst_req) | (w_own_d & data_req);
    assign w_accept  = w_req & addr_ok;

    assign req   = w_req;
    assign wr    = w_own_i ? inst_wr    : data_wr;
    assign size  = w_own_i ? inst_size  : data_size;
    assign addr  = w_own_i ? inst_addr  : data_addr;
    assign wdata = w_own_i ? inst_wdata : data_wdata;

    // addr_ok reaches only the owner. data_ok reaches a side only when it has
    // an accepted transaction (DATA state or the zero-wait acceptance cycle);
    // anything else is a stray data_ok and is dropped.
    assign inst_addr_ok = w_accept & w_own_i;
    assign data_addr_ok = w_accept & w_own_d;
    assign inst_data_ok = data_ok & ((r_state == S_I_DATA) | inst_addr_ok);
    assign data_data_ok = data_ok & ((r_state == S_D_DATA) | data_addr_ok);

    assign inst_rdata = rdata;
    assign data_rdata = rdata;

    // Transaction state and starvation counter, both advanced on acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_starve_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_I_ADDR, S_D_ADDR: begin
                    if (w_own_i | w_own_d) begin
                        if (w_accept) begin
                            if (data_ok) begin
                                r_state <= S_IDLE;
                            end else begin
                                r_state <= w_own_i ? S_I_DATA : S_D_DATA;
                            end
                        end else begin
                            r_state <= w_own_i ? S_I_ADDR : S_D_ADDR;
                        end
                    end
                end
                S_I_DATA, S_D_DATA: begin
                    if (data_ok) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_accept) begin
                if (w_own_i || !inst_req) begin
                    r_starve_cnt <= '0;
                end else if (!w_starved) begin
                    r_starve_cnt <= r_starve_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire
